alu_nibble_seq: RTL and testbench
=================================

# alu_nibble_seq

Multi-cycle sequencer that performs WIDTH-bit add/subtract by driving a single 4-bit add/sub slice once per cycle, least-significant nibble first. The nibble carry or borrow is chained between cycles, the result is assembled in a shift register, and CF/OF/ZF/SF/PF are produced for the full word. It sits between the instruction/control logic and the 4-bit ALU slice, so the narrow adder can serve wide operands with a start/done handshake.

## Interface
- NIBBLES, default 4: number of 4-bit slices per operation; WIDTH = 4*NIBBLES; legal range 2..8.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- ctrl  in  1  1 = add (a+b+cin), 0 = subtract (a-b-cin); latched at accept.
- cin  in  1  carry-in (add) or borrow-in (sub); latched at accept.
- a, b  in  WIDTH  operands; latched at accept.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result and flags valid from this cycle.
- result  out  WIDTH  final sum or difference.
- cf  out  1  carry-out (add) or borrow-out (sub) of the MSB nibble.
- of  out  1  two's-complement signed overflow.
- zf  out  1  result == 0.
- sf  out  1  result[WIDTH-1].
- pf  out  1  1 when result has an even number of 1 bits.

## Operation
- FSM states:
  - IDLE: busy=0, done=0. start=1 → latch a, b, ctrl, cin; clear idx; enter RUN.
  - RUN: busy=1. Each cycle computes nibble idx from a[4idx+3:4idx], b[…] and the chained carry.
    - The 4-bit sum/difference shifts into the top of the result shift register.
    - The nibble carry/borrow-out becomes the next chained carry.
    - idx increments. When idx == NIBBLES-1, flags are registered and the FSM enters DONE.
  - DONE: busy=0, done=1 for exactly one cycle. start=1 here is accepted exactly as in IDLE (back-to-back operation). Otherwise → IDLE.
- Nibble arithmetic:
  - Add: {c,s} = A+B+c.
  - Sub: s = (A-B-c) mod 16; c = 1 when A < B+c.
  - The slice is internal to this block.
- Flags, computed on the final nibble:
  - cf = final carry/borrow.
  - of (add) = (a[MSB]==b[MSB]) && (r[MSB]!=a[MSB]).
  - of (sub) = (a[MSB]!=b[MSB]) && (r[MSB]!=a[MSB]).
  - zf, sf and pf are computed from the complete WIDTH-bit result.
- result and flags hold their values from done until the next done. They do not change during RUN; the working shift register is separate from the result output.
- start while busy=1 is ignored: no queueing, no effect on the current operation.
- Operand inputs may change freely after accept.

## Timing
- Reset values: busy=0, done=0, result=0, cf=of=sf=0, zf=1, pf=1 (consistent with result 0). State = IDLE, idx = 0.
- Start accepted at edge E.
- busy=1 for cycles E+1 .. E+NIBBLES.
- done=1 in cycle E+NIBBLES+1.
- Latency from accept to done: NIBBLES+1 edges. Sustained throughput: one operation per NIBBLES+1 cycles.
- rst=1 at any edge, including mid-RUN or during DONE: the FSM returns to IDLE and all outputs take their reset values. No done is produced for the aborted operation.
- rst and start asserted in the same cycle: rst wins; start is dropped.

## Test plan
- Add 0x1234 + 0x4321, cin=0: done after 5 edges with result=0x5555; cf=0, of=0, zf=0, sf=0, pf=1; busy high for exactly 4 cycles.
- Add 0xFFFF + 0x0001, cin=0: result=0x0000, cf=1, zf=1, of=0, sf=0, pf=1.
- Add 0x7FFF + 0x0000, cin=1: result=0x8000, of=1, sf=1, cf=0, pf=0. Confirms cin propagates through all nibbles.
- Sub 0x0000 - 0x0001: result=0xFFFF, cf=1, sf=1, of=0, pf=1. Then sub 0x8000 - 0x0001: result=0x7FFF, of=1, cf=0, pf=0.
- Busy and back-to-back handling:
  - Pulse start during RUN: ignored; the first result is unchanged.
  - Assert start in the done cycle with 0x0001 + 0x0001: accepted; next done gives result=0x0002.
- Reset handling:
  - Assert rst in the 2nd RUN cycle: next cycle busy=0, result=0, zf=1; no done pulse follows.
  - A subsequent start completes normally.

Source files
------------

// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq
//
// Performs WIDTH-bit add/subtract (WIDTH = 4*NIBBLES) over NIBBLES cycles. One internal 4-bit
// add/sub slice handles one nibble per cycle, least-significant nibble first. The nibble
// carry/borrow is chained between cycles. The finished word and its CF/OF/ZF/SF/PF flags are
// registered on the last nibble.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous, active-high reset
//   start   request; sampled only when busy=0 (IDLE or DONE)
//   ctrl    1 = add (a+b+cin), 0 = subtract (a-b-cin); latched at accept
//   cin     carry-in (add) / borrow-in (sub); latched at accept
//   a, b    WIDTH-bit operands; latched at accept
//   busy    operation in progress
//   done    one-cycle pulse; result and flags valid from this cycle
//   result  final sum or difference; held until the next done
//   cf      carry-out (add) / borrow-out (sub) of the MSB nibble
//   of      two's-complement signed overflow
//   zf      result == 0
//   sf      result MSB
//   pf      1 when result has an even number of 1 bits

module alu_nibble_seq #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   ctrl,
    input  logic                   cin,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cf,
    output logic                   of,
    output logic                   zf,
    output logic                   sf,
    output logic                   pf
);

    localparam int unsigned WIDTH = 4 * NIBBLES;
    localparam int unsigned IdxW  = $clog2(NIBBLES);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              add_q, add_d;
    logic              carry_q, carry_d;    // cin at accept, then the chained nibble carry
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;    // working register, separate from result
    logic [WIDTH-1:0]  result_q, result_d;
    logic              cf_q, cf_d;
    logic              of_q, of_d;
    logic              zf_q, zf_d;
    logic              sf_q, sf_d;
    logic              pf_q, pf_d;

    // 4-bit slice
    logic [3:0]        nib_a;
    logic [3:0]        nib_b;
    logic [4:0]        slice;               // {carry/borrow-out, nibble result}
    logic [WIDTH-1:0]  shreg_next;

    // The lowest nibble falls off the end of the shift register on every step.
    logic              unused_shreg;
    assign unused_shreg = ^shreg_q[3:0];

    always_comb begin
        nib_a = a_q[{idx_q, 2'b00} +: 4];
        nib_b = b_q[{idx_q, 2'b00} +: 4];
        if (add_q) begin
            slice = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
        end else begin
            // A negative 5-bit difference sets bit 4, which is exactly the borrow A < B+c.
            slice = {1'b0, nib_a} - {1'b0, nib_b} - {4'b0000, carry_q};
        end
        shreg_next = {slice[3:0], shreg_q[WIDTH-1:4]};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        add_d    = add_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        result_d = result_q;
        cf_d     = cf_q;
        of_d     = of_q;
        zf_d     = zf_q;
        sf_d     = sf_q;
        pf_d     = pf_q;

        unique case (state_q)
            StIdle, StDone: begin
                // DONE accepts a new request exactly like IDLE for back-to-back operation.
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    add_d   = ctrl;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end

            StRun: begin
                shreg_d = shreg_next;
                carry_d = slice[4];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    result_d = shreg_next;
                    cf_d     = slice[4];
                    if (add_q) begin
                        of_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                               (shreg_next[WIDTH-1] != a_q[WIDTH-1]);
                    end else begin
                        of_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                               (shreg_next[WIDTH-1] != a_q[WIDTH-1]);
                    end
                    zf_d    = (shreg_next == '0);
                    sf_d    = shreg_next[WIDTH-1];
                    pf_d    = ~^shreg_next;
                    state_d = StDone;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            add_q    <= 1'b0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            shreg_q  <= '0;
            result_q <= '0;
            cf_q     <= 1'b0;
            of_q     <= 1'b0;
            zf_q     <= 1'b1;
            sf_q     <= 1'b0;
            pf_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            add_q    <= add_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            result_q <= result_d;
            cf_q     <= cf_d;
            of_q     <= of_d;
            zf_q     <= zf_d;
            sf_q     <= sf_d;
            pf_q     <= pf_d;
        end
    end

    assign busy   = (state_q == StRun);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign cf     = cf_q;
    assign of     = of_q;
    assign zf     = zf_q;
    assign sf     = sf_q;
    assign pf     = pf_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb_alu_nibble_seq
//
// Directed self-checking bench for alu_nibble_seq with NIBBLES=4 (16-bit words). Inputs are driven
// on the falling edge or 1 time unit after the rising edge. Outputs are sampled on the falling edge.

module tb_alu_nibble_seq;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned WIDTH   = 4 * NIBBLES;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             ctrl;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cf;
    logic             of;
    logic             zf;
    logic             sf;
    logic             pf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_nibble_seq #(
        .NIBBLES (NIBBLES)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ctrl   (ctrl),
        .cin    (cin),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cf     (cf),
        .of     (of),
        .zf     (zf),
        .sf     (sf),
        .pf     (pf)
    );

    // Present a request and let one rising edge see it, then scramble the operands.
    task automatic launch(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic vctrl, input logic vcin);
        a     = va;
        b     = vb;
        ctrl  = vctrl;
        cin   = vcin;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'hDEAD;
        b     = 16'hBEEF;
        ctrl  = ~vctrl;
        cin   = ~vcin;
    endtask

    // Returns on the falling edge of the done cycle, or after a 20-cycle bound.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) break;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, lat);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        ctrl  = 1'b0;
        cin   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, result, cf, of, zf, sf, pf} !== {2'b00, 16'h0000, 5'b00101}) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h cf/of/zf/sf/pf=%b, required 0 0 0000 00101",
                     busy, done, result, {cf, of, zf, sf, pf});
        end
        rst = 1'b0;
    endtask

    // Vectors: {a, b, ctrl, cin} -> {result, cf, of, zf, sf, pf}
    task automatic test_arith();
        logic [WIDTH-1:0] va   [7];
        logic [WIDTH-1:0] vb   [7];
        logic             vop  [7];
        logic             vcin [7];
        logic [WIDTH-1:0] er   [7];
        logic [4:0]       ef   [7];
        int lat;
        int bc;
        va[0] = 16'h1234; vb[0] = 16'h4321; vop[0] = 1; vcin[0] = 0; er[0] = 16'h5555; ef[0] = 5'b00001;
        va[1] = 16'hFFFF; vb[1] = 16'h0001; vop[1] = 1; vcin[1] = 0; er[1] = 16'h0000; ef[1] = 5'b10101;
        va[2] = 16'h7FFF; vb[2] = 16'h0000; vop[2] = 1; vcin[2] = 1; er[2] = 16'h8000; ef[2] = 5'b01010;
        va[3] = 16'h0000; vb[3] = 16'h0001; vop[3] = 0; vcin[3] = 0; er[3] = 16'hFFFF; ef[3] = 5'b10011;
        va[4] = 16'h8000; vb[4] = 16'h0001; vop[4] = 0; vcin[4] = 0; er[4] = 16'h7FFF; ef[4] = 5'b01000;
        va[5] = 16'h0010; vb[5] = 16'h0001; vop[5] = 0; vcin[5] = 1; er[5] = 16'h000E; ef[5] = 5'b00000;
        va[6] = 16'h5555; vb[6] = 16'h5555; vop[6] = 0; vcin[6] = 0; er[6] = 16'h0000; ef[6] = 5'b00101;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            launch(va[i], vb[i], vop[i], vcin[i]);
            wait_done(lat, bc);
            n_checks++;
            if ({result, cf, of, zf, sf, pf} !== {er[i], ef[i]}) begin
                n_fail++;
                $display("FAIL arith_%0d: got result=%h cf/of/zf/sf/pf=%b, required %h %b",
                         i, result, {cf, of, zf, sf, pf}, er[i], ef[i]);
            end
            n_checks++;
            if (lat != 5 || bc != 4) begin
                n_fail++;
                $display("FAIL timing_%0d: got done at cycle %0d busy for %0d, required 5 and 4",
                         i, lat, bc);
            end
            if (i == 0) begin
                @(negedge clk);
                n_checks++;
                if ({done, busy} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL done_pulse: got done=%b busy=%b after done, required 0 0",
                             done, busy);
                end
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        int bc;
        int extra_done;
        @(negedge clk);
        launch(16'h1234, 16'h4321, 1'b1, 1'b0);
        @(negedge clk);
        a     = 16'h1111;
        b     = 16'h1111;
        ctrl  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        n_checks++;
        if ({result, cf, of, zf, sf, pf} !== {16'h5555, 5'b00001}) begin
            n_fail++;
            $display("FAIL busy_ignore: got result=%h flags=%b, required 5555 00001",
                     result, {cf, of, zf, sf, pf});
        end
        extra_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra_done++;
        end
        n_checks++;
        if (extra_done != 0) begin
            n_fail++;
            $display("FAIL busy_no_queue: got %0d active cycles after done, required 0", extra_done);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int bc;
        @(negedge clk);
        launch(16'h00FF, 16'h0001, 1'b1, 1'b0);
        wait_done(lat, bc);
        n_checks++;
        if ({result, cf, of, zf, sf, pf} !== {16'h0100, 5'b00000}) begin
            n_fail++;
            $display("FAIL b2b_first: got result=%h flags=%b, required 0100 00000",
                     result, {cf, of, zf, sf, pf});
        end
        // Still in the done cycle: issue the next request.
        launch(16'h0001, 16'h0001, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({busy, result} !== {1'b1, 16'h0100}) begin
            n_fail++;
            $display("FAIL b2b_accept_hold: got busy=%b result=%h, required 1 0100", busy, result);
        end
        wait_done(lat, bc);
        n_checks++;
        if ({result, cf, of, zf, sf, pf} !== {16'h0002, 5'b00000}) begin
            n_fail++;
            $display("FAIL b2b_second: got result=%h flags=%b, required 0002 00000",
                     result, {cf, of, zf, sf, pf});
        end
        n_checks++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL b2b_latency: got done at cycle %0d, required 4", lat);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int bc;
        int active;
        @(negedge clk);
        launch(16'h1234, 16'h4321, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, result, cf, of, zf, sf, pf} !== {2'b00, 16'h0000, 5'b00101}) begin
            n_fail++;
            $display("FAIL reset_mid_run: got busy=%b done=%b result=%h flags=%b, required 0 0 0000 00101",
                     busy, done, result, {cf, of, zf, sf, pf});
        end
        active = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) active++;
        end
        n_checks++;
        if (active != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d active cycles after abort, required 0", active);
        end
        // rst and start together: start is dropped.
        rst   = 1'b1;
        start = 1'b1;
        a     = 16'h0F0F;
        b     = 16'h0101;
        ctrl  = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        active = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) active++;
        end
        n_checks++;
        if (active != 0) begin
            n_fail++;
            $display("FAIL reset_wins: got %0d active cycles after rst+start, required 0", active);
        end
        @(negedge clk);
        launch(16'h1234, 16'h4321, 1'b1, 1'b0);
        wait_done(lat, bc);
        n_checks++;
        if ({result, cf, of, zf, sf, pf, lat} !== {16'h5555, 5'b00001, 32'd5}) begin
            n_fail++;
            $display("FAIL after_reset_op: got result=%h flags=%b lat=%0d, required 5555 00001 5",
                     result, {cf, of, zf, sf, pf}, lat);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
